serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial ripple-borrow subtractor computing d = a − b − bin over WIDTH bits, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the sequential counterpart to the combinational ripple-carry adder in the arithmetic library. It targets area-constrained datapaths, where one cell is reused WIDTH times instead of replicating WIDTH cells. A start/busy/done handshake frames each operation; the result stays stable between operations.

## Interface
- WIDTH, 4: operand and result width in bits; legal values are ≥ 2.
- clk  in  1  Rising-edge clock; the block uses this one clock only.
- rst  in  1  Asynchronous, active-high reset.
- start  in  1  Request to begin an operation; sampled on each rising clk edge.
- a  in  WIDTH  Minuend; sampled only on the accepting edge.
- b  in  WIDTH  Subtrahend; sampled only on the accepting edge.
- bin  in  1  Borrow-in; sampled only on the accepting edge.
- d  out  WIDTH  Registered difference, equal to (a − b − bin) mod 2^WIDTH.
- bout  out  1  Registered borrow-out; equals 1 exactly when a < b + bin (unsigned).
- busy  out  1  High while an operation is in progress.
- done  out  1  Single-cycle pulse indicating that d and bout were just updated.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- Reset forces state=IDLE and clears d, bout, busy, done, the bit counter, the borrow register and the shift registers to 0.
- Accept: on an edge where start=1 and state is IDLE or DONE:
  - load a, b and bin into the internal registers sa, sb and br;
  - set the counter to 0;
  - move to SHIFT.
- start=1 while in SHIFT is ignored; the operation in progress is unaffected.
- SHIFT performs one bit per edge, with x=sa[0], y=sb[0] and z=br:
  - the difference bit is x^y^z;
  - the new borrow is (~x&y) | (~x&z) | (y&z);
  - br takes the new borrow;
  - sa and sb shift right by one;
  - the difference bit is shifted into the MSB of an internal shift register sd;
  - the counter increments.
- On the edge that processes bit WIDTH−1:
  - d is loaded with the completed sd value, including that final bit;
  - bout is loaded with the final borrow;
  - the state moves to DONE.
- DONE lasts one cycle. The next state is SHIFT if start=1, otherwise IDLE.
- d and bout change only on the completion edge or on reset. They are never exposed while partially computed.
- Arithmetic is unsigned modulo 2^WIDTH; no other overflow indication exists.
- Reset asserted mid-operation aborts the operation immediately. No done pulse follows, and d and bout read 0.

## Timing
- Call the accepting edge E0.
- Bits 0 through WIDTH−1 are processed on edges E1 through E_WIDTH.
- Latency is WIDTH edges from acceptance to the result.
- busy is 1 from E0 to E_WIDTH, which is WIDTH cycles. It is 0 in IDLE and DONE.
- done is 1 for exactly one cycle, from E_WIDTH to E_WIDTH+1.
- The result d/bout is valid from E_WIDTH onward and holds until the next completion edge or reset.
- Back-to-back operation:
  - start=1 during the DONE cycle is accepted at E_WIDTH+1;
  - throughput is therefore one result per WIDTH+1 cycles;
  - in that case done falls and busy rises on the same edge.
- Operand changes on a, b or bin after E0 have no effect on the operation in progress.
- All outputs come directly from registers; no combinational path runs from any input to any output.

## Test plan
- WIDTH=4, a=9, b=3, bin=0 → d=6, bout=0. done pulses one cycle, exactly 4 edges after acceptance; busy is high for 4 cycles.
- a=3, b=9, bin=0 → d=0xA, bout=1. Also a=0, b=0, bin=1 → d=0xF, bout=1.
- a=15, b=15, bin=1 → d=0xF, bout=1. Also a=15, b=0, bin=0 → d=0xF, bout=0.
- Change a and b, and pulse start, while busy=1 → the first result is unchanged and no extra done pulse occurs. Then start during DONE with a=5, b=2 → d=3 after 4 more edges, with no IDLE cycle between the two operations.
- Assert rst at the 2nd SHIFT edge of a=12, b=1 → d=0, bout=0, busy=0, done=0 immediately, with no done pulse afterwards. The next operation a=7, b=7 completes correctly with d=0, bout=0.
- Exhaustive sweep over a, b in 0..15 and bin in {0,1} (512 operations, back-to-back) → each d and bout matches a scoreboard computing (a−b−bin) mod 16 and a<b+bin. Repeat 1000 random operations with WIDTH=8.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: the master drives start and operands,
// the slave returns the registered difference, borrow-out and busy/done status.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  d, bout, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output d, bout, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial d = a - b - bin, LSB first, one full-subtractor cell reused WIDTH times.
// Result WIDTH cycles after the accepting edge; start is ignored while busy (no other backpressure).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic [WIDTH-1:0] r_d;
  logic             r_br;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic w_x;
  logic w_y;
  logic w_z;
  logic w_dbit;
  logic w_bnew;
  logic w_last;
  logic w_accept;

  assign w_x      = r_sa[0];
  assign w_y      = r_sb[0];
  assign w_z      = r_br;
  assign w_dbit   = w_x ^ w_y ^ w_z;
  assign w_bnew   = (~w_x & w_y) | (~w_x & w_z) | (w_y & w_z);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last)    w_next = ST_DONE;
      ST_DONE:  w_next = bus.start ? ST_SHIFT : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // busy/done are registered from the next-state decode so every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_sd   <= '0;
      r_d    <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_busy <= (w_next == ST_SHIFT);
      r_done <= (r_state == ST_SHIFT) && w_last;
      if (w_accept) begin
        r_sa  <= bus.a;
        r_sb  <= bus.b;
        r_br  <= bus.bin;
        r_cnt <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_br  <= w_bnew;
        r_sd  <= {w_dbit, r_sd[WIDTH-1:1]};
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_d    <= {w_dbit, r_sd[WIDTH-1:1]};
          r_bout <= w_bnew;
        end
      end
    end
  end

  assign bus.d    = r_d;
  assign bus.bout = r_bout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=4 and WIDTH=8 against
// a plain-arithmetic reference: d = (a - b - bin) mod 2^W, bout = (a < b + bin).
module tb_serial_subtractor;
  logic clk;
  logic rst;
  int   n_err;
  int   n_checks;
  logic [7:0] prev_d [2];
  logic       prev_b [2];

  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic bin);
    if (w == 4) begin
      bus4.start = st; bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.bin = bin;
    end else begin
      bus8.start = st; bus8.a = a; bus8.b = b; bus8.bin = bin;
    end
  endtask

  function automatic logic [7:0] get_d(input int w);
    return (w == 4) ? {4'b0, bus4.d} : bus8.d;
  endfunction
  function automatic logic get_bout(input int w);
    return (w == 4) ? bus4.bout : bus8.bout;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 4) ? bus4.busy : bus8.busy;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 4) ? bus4.done : bus8.done;
  endfunction

  // Accepts at the next edge (caller must be in IDLE or DONE); returns one
  // nanosecond after the completion edge, i.e. inside the DONE cycle.
  task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input bit full, input bit disturb, input string tag);
    int         idx;
    int         mask;
    logic [7:0] exp_d;
    logic       exp_b;
    idx   = (w == 4) ? 0 : 1;
    mask  = (1 << w) - 1;
    exp_d = 8'((int'(a) - int'(b) - int'(bin)) & mask);
    exp_b = (int'(a) < int'(b) + int'(bin));
    drive(w, 1'b1, a, b, bin);
    tick();
    if (full) begin
      chk({tag, "_busy_e0"}, get_busy(w), 1'b1);
      chk({tag, "_done_e0"}, get_done(w), 1'b0);
    end
    drive(w, 1'b0, a, b, bin);
    for (int k = 1; k <= w; k++) begin
      if (disturb && k == 2) drive(w, 1'b1, ~a, ~b, ~bin);
      if (disturb && k == 3) drive(w, 1'b0, ~a, ~b, ~bin);
      tick();
      if (full && k < w) begin
        chk({tag, "_busy_mid"}, get_busy(w), 1'b1);
        chk({tag, "_done_mid"}, get_done(w), 1'b0);
        chk({tag, "_d_hold"}, get_d(w), prev_d[idx]);
      end
    end
    chk({tag, "_d"}, get_d(w), exp_d);
    chk({tag, "_bout"}, get_bout(w), exp_b);
    chk({tag, "_done"}, get_done(w), 1'b1);
    if (full) chk({tag, "_busy_end"}, get_busy(w), 1'b0);
    prev_d[idx] = exp_d;
    prev_b[idx] = exp_b;
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    prev_d[0] = '0; prev_d[1] = '0;
    prev_b[0] = 1'b0; prev_b[1] = 1'b0;
    rst = 1'b1;
    drive(4, 1'b0, 8'h0, 8'h0, 1'b0);
    drive(8, 1'b0, 8'h0, 8'h0, 1'b0);
    #1;
    chk("rst_d", get_d(4), 8'h0);
    chk("rst_bout", get_bout(4), 1'b0);
    chk("rst_busy", get_busy(4), 1'b0);
    chk("rst_done", get_done(4), 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    do_op(4, 8'd9, 8'd3, 1'b0, 1'b1, 1'b0, "sub9_3");
    tick();
    chk("sub9_3_done_one_cycle", get_done(4), 1'b0);
    chk("sub9_3_d_stable", get_d(4), 8'h6);
    tick();
    do_op(4, 8'd3, 8'd9, 1'b0, 1'b1, 1'b0, "sub3_9");
    tick();
    do_op(4, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, "sub0_0_1");
    tick();
    do_op(4, 8'd15, 8'd15, 1'b1, 1'b1, 1'b0, "sub15_15_1");
    tick();
    do_op(4, 8'd15, 8'd0, 1'b0, 1'b1, 1'b0, "sub15_0");
    tick();

    // Disturbed operands/start mid-operation, then back-to-back start in DONE.
    do_op(4, 8'd9, 8'd3, 1'b0, 1'b1, 1'b1, "ignore");
    do_op(4, 8'd5, 8'd2, 1'b0, 1'b1, 1'b0, "b2b");
    tick();
    chk("b2b_done_fall", get_done(4), 1'b0);

    // Reset in the middle of a=12, b=1 aborts it with no done pulse.
    drive(4, 1'b1, 8'd12, 8'd1, 1'b0);
    tick();
    drive(4, 1'b0, 8'd12, 8'd1, 1'b0);
    tick();
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("abort_d", get_d(4), 8'h0);
    chk("abort_bout", get_bout(4), 1'b0);
    chk("abort_busy", get_busy(4), 1'b0);
    chk("abort_done", get_done(4), 1'b0);
    prev_d[0] = '0; prev_b[0] = 1'b0;
    prev_d[1] = '0; prev_b[1] = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("abort_no_done", get_done(4), 1'b0);
      chk("abort_idle_busy", get_busy(4), 1'b0);
    end
    do_op(4, 8'd7, 8'd7, 1'b0, 1'b1, 1'b0, "after_abort");
    tick();

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          do_op(4, 8'(a), 8'(b), 1'(c), 1'b0, 1'b0, "sweep4");
    tick();

    for (int n = 0; n < 1000; n++)
      do_op(8, 8'($urandom), 8'($urandom), 1'($urandom), (n < 4), 1'b0, "rand8");
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
